// File: rtl/decoder_3x8_pkg.sv
// Shared widths and the code-to-one-hot decode used by the decoder_3x8 slice.
package decoder_3x8_pkg;

    localparam int unsigned CODE_W   = 3;
    localparam int unsigned ONEHOT_W = 8;

    function automatic logic [ONEHOT_W-1:0] decode_onehot(input logic [CODE_W-1:0] code);
        return ONEHOT_W'(1) << code;
    endfunction

endpackage

// File: rtl/code_fifo.sv
// Circular buffer of DEPTH entries with wrapping pointers and an occupancy counter.
module code_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push_valid,
    output logic             o_push_ready,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop_ready,
    output logic             o_pop_valid,
    output logic [WIDTH-1:0] o_head_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    // A pop while full does not open the slot until the next cycle.
    assign w_push  = i_push_valid & ~w_full;
    assign w_pop   = i_pop_ready & ~w_empty;

    assign o_push_ready = ~w_full;
    assign o_pop_valid  = ~w_empty;
    assign o_full       = w_full;
    assign o_empty      = w_empty;
    assign o_head_data  = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule

// File: rtl/decoder_3x8.sv
// Buffered 3-to-8 decoder: codes queue in code_fifo, the head is decoded to one-hot.
module decoder_3x8 #(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] d,
    output logic       full,
    output logic       empty,
    output logic [7:0] xfer_cnt
);

    import decoder_3x8_pkg::*;

    logic [CODE_W-1:0] w_head;
    logic              w_out_valid;
    logic              w_pop;
    logic [7:0]        r_xfer_cnt;

    code_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CODE_W)
    ) u_code_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push_valid (in_valid),
        .o_push_ready (in_ready),
        .i_push_data  ({a, b, c}),
        .i_pop_ready  (out_ready),
        .o_pop_valid  (w_out_valid),
        .o_head_data  (w_head),
        .o_full       (full),
        .o_empty      (empty)
    );

    assign w_pop     = w_out_valid & out_ready;
    assign out_valid = w_out_valid;
    // Gate with valid so stale storage never reaches d.
    assign d         = w_out_valid ? decode_onehot(w_head) : '0;
    assign xfer_cnt  = r_xfer_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_cnt <= '0;
        end else if (w_pop) begin
            r_xfer_cnt <= r_xfer_cnt + 8'd1;
        end
    end

endmodule
